// File: rtl/divider_arbiter_if.sv
// Requester-side channel of the divider arbiter: a command handshake and a response handshake.
interface divider_arbiter_if #(
   parameter int unsigned WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic             req_sgn;
   logic [WIDTH-1:0] req_num;
   logic [WIDTH-1:0] req_denom;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_quot;
   logic [WIDTH-1:0] rsp_rem;

   modport master (
      output req_valid, req_sgn, req_num, req_denom, rsp_ready,
      input  req_ready, rsp_valid, rsp_quot, rsp_rem
   );

   modport slave (
      input  req_valid, req_sgn, req_num, req_denom, rsp_ready,
      output req_ready, rsp_valid, rsp_quot, rsp_rem
   );
endinterface

// File: rtl/divider_arbiter.sv
// Two-requester round-robin front end for a single shared non-restoring divider.
// One transaction at a time: grant, issue one command strobe, wait, hold the result.
module divider_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   divider_arbiter_if.slave req0,
   divider_arbiter_if.slave req1,
   output logic             div_enable,
   output logic             div_unsgn_or_sgn,
   output logic [WIDTH-1:0] div_num,
   output logic [WIDTH-1:0] div_denom,
   input  logic [WIDTH-1:0] div_quot,
   input  logic [WIDTH-1:0] div_rem,
   input  logic             div_can_accept_cmd,
   input  logic             div_data_ready
);

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e           state_q, state_d;
   logic             prio_q, prio_d;
   logic             owner_q;
   logic             sgn_q;
   logic [WIDTH-1:0] num_q, denom_q, quot_q, rem_q;

   logic grant0, grant1, accept, capture, rsp_taken;

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      grant0  = 1'b0;
      grant1  = 1'b0;
      accept  = 1'b0;
      capture = 1'b0;
      rsp_taken = owner_q ? req1.rsp_ready : req0.rsp_ready;
      unique case (state_q)
         StIdle: begin
            // Grants are suppressed while rst is high so no ready leaks during reset.
            if (!rst && div_can_accept_cmd && (req0.req_valid || req1.req_valid)) begin
               grant0  = req0.req_valid && (!req1.req_valid || !prio_q);
               grant1  = !grant0;
               accept  = 1'b1;
               state_d = StIssue;
            end
         end
         StIssue: state_d = StWait;
         StWait: begin
            if (div_data_ready) begin
               capture = 1'b1;
               state_d = StResp;
            end
         end
         StResp: begin
            if (rsp_taken) begin
               prio_d  = ~owner_q;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         prio_q  <= 1'b0;
         owner_q <= 1'b0;
         sgn_q   <= 1'b0;
         num_q   <= '0;
         denom_q <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         if (accept) begin
            owner_q <= grant1;
            sgn_q   <= grant1 ? req1.req_sgn   : req0.req_sgn;
            num_q   <= grant1 ? req1.req_num   : req0.req_num;
            denom_q <= grant1 ? req1.req_denom : req0.req_denom;
         end
         if (capture) begin
            quot_q <= div_quot;
            rem_q  <= div_rem;
         end
      end
   end

   assign req0.req_ready = grant0;
   assign req1.req_ready = grant1;

   assign req0.rsp_valid = !rst && (state_q == StResp) && !owner_q;
   assign req1.rsp_valid = !rst && (state_q == StResp) &&  owner_q;
   assign req0.rsp_quot  = quot_q;
   assign req0.rsp_rem   = rem_q;
   assign req1.rsp_quot  = quot_q;
   assign req1.rsp_rem   = rem_q;

   assign div_enable       = !rst && (state_q == StIssue);
   assign div_unsgn_or_sgn = sgn_q;
   assign div_num          = num_q;
   assign div_denom        = denom_q;

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed and randomized checks of divider_arbiter against a behavioural divide model.
module tb_divider_arbiter;
   localparam int unsigned W = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          div_enable, div_sgn, can_accept, div_data_ready;
   logic [W-1:0]  div_num, div_denom, div_quot, div_rem;
   logic          auto_rdy, man_rdy;
   logic          auto_div;
   int            div_lat;
   int            tests = 0;
   int            fails = 0;
   bit            mon_on = 1'b0;

   divider_arbiter_if #(.WIDTH(W)) if0 ();
   divider_arbiter_if #(.WIDTH(W)) if1 ();

   divider_arbiter #(.WIDTH(W)) dut (
      .clk                (clk),
      .rst                (rst),
      .req0               (if0),
      .req1               (if1),
      .div_enable         (div_enable),
      .div_unsgn_or_sgn   (div_sgn),
      .div_num            (div_num),
      .div_denom          (div_denom),
      .div_quot           (div_quot),
      .div_rem            (div_rem),
      .div_can_accept_cmd (can_accept),
      .div_data_ready     (div_data_ready)
   );

   always #5 clk = ~clk;

   assign div_data_ready = auto_rdy | man_rdy;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] n,
                                           input logic [31:0] d);
      logic [31:0] q, r;
      if (sgn) begin
         q = $signed(n) / $signed(d);
         r = $signed(n) % $signed(d);
      end else begin
         q = n / d;
         r = n % d;
      end
      return {q, r};
   endfunction

   // Stand-in divider: answers each command strobe after div_lat cycles.
   int          cnt = 0;
   bit          busy = 1'b0;
   logic [63:0] res;
   always @(negedge clk) begin
      auto_rdy = 1'b0;
      if (busy) begin
         cnt--;
         if (cnt == 0) begin
            busy = 1'b0;
            auto_rdy = 1'b1;
            {div_quot, div_rem} = res;
         end
      end
      if (div_enable && auto_div) begin
         res  = ref_div(div_sgn, div_num, div_denom);
         cnt  = div_lat;
         busy = 1'b1;
      end
   end

   bit prev_en = 1'b0;
   always @(negedge clk) begin
      #2;
      if (mon_on) begin
         chk("one_ready", 64'(if0.req_ready & if1.req_ready), 64'd0);
         chk("one_rsp", 64'(if0.rsp_valid & if1.rsp_valid), 64'd0);
         chk("ready_needs_accept", 64'((if0.req_ready | if1.req_ready) & ~can_accept), 64'd0);
         chk("enable_one_cycle", 64'(prev_en & div_enable), 64'd0);
      end
      prev_en = div_enable;
   end

   task automatic drive_req(input bit who, input logic v, input logic s, input logic [31:0] n,
                            input logic [31:0] d);
      if (who) begin
         if1.req_valid = v; if1.req_sgn = s; if1.req_num = n; if1.req_denom = d;
      end else begin
         if0.req_valid = v; if0.req_sgn = s; if0.req_num = n; if0.req_denom = d;
      end
   endtask

   function automatic logic rdy(input bit who);
      return who ? if1.req_ready : if0.req_ready;
   endfunction

   function automatic logic rspv(input bit who);
      return who ? if1.rsp_valid : if0.rsp_valid;
   endfunction

   function automatic logic [63:0] rspd(input bit who);
      return who ? {if1.rsp_quot, if1.rsp_rem} : {if0.rsp_quot, if0.rsp_rem};
   endfunction

   task automatic set_rsp_ready(input bit who, input logic v);
      if (who) if1.rsp_ready = v;
      else     if0.rsp_ready = v;
   endtask

   // Entered and left at negedge+1 of a cycle.
   task automatic run_txn(input bit who, input logic sgn, input logic [31:0] n,
                          input logic [31:0] d, input int hold, input logic [63:0] exp);
      int waited;
      drive_req(who, 1'b1, sgn, n, d);
      #1;
      waited = 0;
      while (!rdy(who) && waited < 30) begin
         @(negedge clk); #1; waited++;
      end
      chk("grant", 64'(rdy(who)), 64'd1);
      @(negedge clk);
      drive_req(who, 1'b0, 1'b0, '0, '0);
      #1;
      chk("issue_enable", 64'(div_enable), 64'd1);
      chk("issue_num", 64'(div_num), 64'(n));
      chk("issue_denom", 64'(div_denom), 64'(d));
      chk("issue_sgn", 64'(div_sgn), 64'(sgn));
      waited = 1;
      while (!rspv(who) && waited < 40) begin
         chk("other_rsp_low", 64'(rspv(!who)), 64'd0);
         @(negedge clk); #1; waited++;
      end
      chk("latency", 64'(waited), 64'(2 + div_lat));
      for (int i = 0; i <= hold; i++) begin
         chk("rsp_valid", 64'(rspv(who)), 64'd1);
         chk("rsp_data", rspd(who), exp);
         chk("other_ready_held", 64'(rdy(!who)), 64'd0);
         chk("other_rsp", 64'(rspv(!who)), 64'd0);
         if (i < hold) begin
            @(negedge clk); #1;
         end
      end
      set_rsp_ready(who, 1'b1);
      @(negedge clk);
      set_rsp_ready(who, 1'b0);
      #1;
      chk("rsp_drop", 64'(rspv(who)), 64'd0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      drive_req(0, 1'b1, 1'b0, 32'd9, 32'd3);
      drive_req(1, 1'b0, 1'b0, '0, '0);
      #1;
      chk("ready_in_reset", 64'(if0.req_ready), 64'd0);
      @(negedge clk);
      drive_req(0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_enable", 64'(div_enable), 64'd0);
      chk("rst_rsp0", 64'(if0.rsp_valid), 64'd0);
      chk("rst_rsp1", 64'(if1.rsp_valid), 64'd0);
      chk("rst_num", 64'(div_num), 64'd0);
      chk("rst_denom", 64'(div_denom), 64'd0);
      chk("rst_sgn", 64'(div_sgn), 64'd0);
      chk("rst_quot", 64'(if0.rsp_quot), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      int grants, rsps, last_g, cyc;
      bit drop;
      logic [31:0] n, d;
      logic s;
      bit w;
      rst = 1'b0; can_accept = 1'b1; auto_div = 1'b1; div_lat = 3; man_rdy = 1'b0;
      div_quot = '0; div_rem = '0;
      drive_req(0, 1'b0, 1'b0, '0, '0);
      drive_req(1, 1'b0, 1'b0, '0, '0);
      if0.rsp_ready = 1'b0; if1.rsp_ready = 1'b0;
      do_reset();
      mon_on = 1'b1;

      // Single unsigned request
      run_txn(0, 1'b0, 32'd100, 32'd7, 3, {32'd14, 32'd2});

      // Both valid after reset: req0 first, then signed req1
      do_reset();
      drive_req(1, 1'b1, 1'b1, 32'hFFFF_FFEC, 32'd3);
      drive_req(0, 1'b1, 1'b0, 32'd55, 32'd10);
      #1;
      chk("both_first_req0", 64'(if0.req_ready), 64'd1);
      chk("both_not_req1", 64'(if1.req_ready), 64'd0);
      run_txn(0, 1'b0, 32'd55, 32'd10, 1, {32'd5, 32'd5});
      chk("req1_next", 64'(if1.req_ready), 64'd1);
      run_txn(1, 1'b1, 32'hFFFF_FFEC, 32'd3, 2, {32'hFFFF_FFFA, 32'hFFFF_FFFE});

      // Req0 continuously valid for three back-to-back commands
      div_lat = 2;
      grants = 0; rsps = 0; last_g = 0; drop = 1'b0;
      if0.rsp_ready = 1'b1;
      drive_req(0, 1'b1, 1'b0, 32'd1000, 32'd33);
      #1;
      for (cyc = 0; cyc < 80 && rsps < 3; cyc++) begin
         if (if0.req_ready) begin
            grants++;
            if (grants > 1) chk("b2b_gap", 64'(cyc - last_g), 64'(3 + div_lat));
            last_g = cyc;
            if (grants == 3) drop = 1'b1;
         end
         if (if0.rsp_valid) begin
            rsps++;
            chk("b2b_data", {if0.rsp_quot, if0.rsp_rem}, ref_div(1'b0, 32'd1000, 32'd33));
         end
         if (rsps < 3) begin
            @(negedge clk);
            if (drop) drive_req(0, 1'b0, 1'b0, '0, '0);
            #1;
         end
      end
      chk("b2b_grants", 64'(grants), 64'd3);
      @(negedge clk);
      if0.rsp_ready = 1'b0;
      #1;

      // Divider busy blocks the grant
      can_accept = 1'b0;
      drive_req(1, 1'b1, 1'b0, 32'd81, 32'd9);
      #1;
      for (int i = 0; i < 5; i++) begin
         chk("blocked_ready", 64'(if1.req_ready), 64'd0);
         chk("blocked_enable", 64'(div_enable), 64'd0);
         @(negedge clk); #1;
      end
      can_accept = 1'b1;
      run_txn(1, 1'b0, 32'd81, 32'd9, 0, {32'd9, 32'd0});

      // Stalled response with req1 waiting
      drive_req(1, 1'b1, 1'b0, 32'd77, 32'd8);
      run_txn(0, 1'b0, 32'd123456, 32'd1000, 10, {32'd123, 32'd456});
      chk("req1_after_release", 64'(if1.req_ready), 64'd1);
      run_txn(1, 1'b0, 32'd77, 32'd8, 0, {32'd9, 32'd5});

      // Randomized transactions
      for (int k = 0; k < 12; k++) begin
         w = 1'($urandom_range(0, 1));
         s = 1'($urandom_range(0, 1));
         n = $urandom;
         d = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 1000)) : $urandom;
         if (d == 0) d = 32'd1;
         if (s && n == 32'h8000_0000 && d == 32'hFFFF_FFFF) d = 32'd1;
         div_lat = $urandom_range(1, 4);
         run_txn(w, s, n, d, $urandom_range(0, 3), ref_div(s, n, d));
      end

      // Reset while waiting on the divider; late data_ready must be ignored
      div_lat = 2;
      run_txn(0, 1'b0, 32'd10, 32'd3, 0, {32'd3, 32'd1});
      auto_div = 1'b0;
      drive_req(1, 1'b1, 1'b0, 32'd50, 32'd5);
      #1;
      chk("rst_case_grant", 64'(if1.req_ready), 64'd1);
      @(negedge clk);
      drive_req(1, 1'b0, 1'b0, '0, '0);
      #1;
      chk("rst_case_issue", 64'(div_enable), 64'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_case_num", 64'(div_num), 64'd0);
      @(negedge clk);
      man_rdy = 1'b1;
      #1;
      chk("late_rdy_rsp1", 64'(if1.rsp_valid), 64'd0);
      @(negedge clk);
      man_rdy = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("late_rsp0", 64'(if0.rsp_valid), 64'd0);
         chk("late_rsp1", 64'(if1.rsp_valid), 64'd0);
         @(negedge clk); #1;
      end
      auto_div = 1'b1;
      drive_req(0, 1'b1, 1'b0, 32'd64, 32'd8);
      drive_req(1, 1'b1, 1'b0, 32'd65, 32'd8);
      #1;
      chk("prio_reset_req0", 64'(if0.req_ready), 64'd1);
      chk("prio_reset_req1", 64'(if1.req_ready), 64'd0);
      run_txn(0, 1'b0, 32'd64, 32'd8, 0, {32'd8, 32'd0});
      run_txn(1, 1'b0, 32'd65, 32'd8, 0, {32'd8, 32'd1});

      mon_on = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/divider_arbiter.md
DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set operand and result width (32 or 64, matching the divmod32 or divmod64 divider it fronts).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 reqN_valid  in  1  (N=0,1) requester N presents a divide command.
REQ-005 reqN_ready  out  1  command from requester N accepted this cycle.
REQ-006 reqN_sgn  in  1  0 = unsigned, 1 = signed (drives the divider's unsgn_or_sgn).
REQ-007 reqN_num, reqN_denom  in  WIDTH  dividend and divisor.
REQ-008 rspN_valid  out  1  result for requester N available.
REQ-009 rspN_ready  in  1  requester N consumes the result.
REQ-010 rspN_quot, rspN_rem  out  WIDTH  quotient and remainder.
REQ-011 div_enable, div_unsgn_or_sgn  out  1  command strobe and signedness to the NonRestoringDivider.
REQ-012 div_num, div_denom  out  WIDTH  divider operands.
REQ-013 div_quot, div_rem  in  WIDTH  divider results.
REQ-014 div_can_accept_cmd, div_data_ready  in  1  divider status.

Function
REQ-015 The FSM SHALL have exactly four states, IDLE, ISSUE, WAIT and RESP, plus a 1-bit round-robin pointer prio and a 1-bit owner register.
REQ-016 IDLE: when any reqN_valid=1 and div_can_accept_cmd=1, the SHALL logic grant one requester; reqN_ready SHALL be combinationally high for that requester only, in that cycle only.
REQ-017 Grant choice: only one valid -> that one; both valid -> requester prio.
REQ-018 On the accepting edge, the block SHALL latch sgn/num/denom and owner=N, then go to ISSUE.
REQ-019 ISSUE: div_enable=1 for exactly one cycle with the latched operands on div_*; the FSM then goes to WAIT.
REQ-020 WAIT: div_enable=0; on the first edge with div_data_ready=1, the block SHALL latch div_quot/div_rem and go to RESP.
REQ-021 RESP: rsp{owner}_valid=1, and the latched results SHALL stay stable until the edge where rsp{owner}_ready=1; on that edge prio <= ~owner and the FSM returns to IDLE.
REQ-022 The other requester's rsp_valid SHALL remain 0 throughout.
REQ-023 Latency: if a command is accepted at edge T and div_data_ready is first seen at edge D, rsp_valid SHALL rise in the cycle after D; the minimum gap between transactions is one IDLE cycle.
REQ-024 div_data_ready SHALL be ignored in IDLE, ISSUE and RESP.
REQ-025 div_can_accept_cmd=0 in IDLE SHALL block all grants; no reqN_ready may assert.
REQ-026 reqN_valid dropping before its ready is legal and SHALL not affect the FSM; requesters hold operands stable while valid.
REQ-027 Results SHALL pass through unmodified; divide-by-zero and signed overflow behaviour is whatever the divider returns.
REQ-028 div_num, div_denom and div_unsgn_or_sgn SHALL be driven from the latched registers in every state.

Reset
REQ-029 Reset SHALL force: state IDLE, prio=0, owner=0, div_enable=0, all reqN_ready and rspN_valid 0, and latched operand/result registers 0.
REQ-030 Reset asserted in any state SHALL abandon the transaction with no rsp_valid pulse; a late div_data_ready after reset SHALL be ignored.
REQ-031 Reset SHALL take priority over every other event on the same edge.

Verification
REQ-032 Only req0 valid, unsigned, num=100, denom=7 -> one-cycle req0_ready, one-cycle div_enable, then rsp0_valid with quot=14, rem=2 held until rsp0_ready.
REQ-033 Both valid after reset, req1 signed num=-20 (0xFFFFFFEC), denom=3 -> req0 served first, then req1 with quot=-6 (0xFFFFFFFA), rem=-2 (0xFFFFFFFE); rsp0_valid never high during req1's transaction.
REQ-034 req0 continuously valid, req1 idle, 3 commands -> three back-to-back grants to req0, each separated by at least one IDLE cycle.
REQ-035 div_can_accept_cmd=0 for 5 cycles with req1 valid -> no req1_ready and no div_enable until the cycle can_accept_cmd returns to 1.
REQ-036 rst asserted in WAIT, div_data_ready pulsed 2 cycles later -> no rsp_valid, FSM IDLE, prio=0.
REQ-037 rsp0_ready held low 10 cycles in RESP with req1 valid -> rsp0 data stable, no req1_ready until release, then req1 granted.
